alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage feeding the execute-stage ALU in the pipelined MIPS core. Takes a fetched instruction word plus register-file read data, produces the ALU 6-bit function code, both ALU operands, and writeback controls, and registers them into the ID/EX pipeline boundary. Supports stall (hold) and flush (bubble insertion) from the hazard unit. Latency one cycle.

## Interface
- No parameters; widths fixed: 32-bit datapath, 6-bit function code, 5-bit register index.
- Reset is synchronous and active-high; single clock domain.
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  instruction in decode slot is real (0 = bubble)
- i_instr  in  32  instruction word
- i_pc  in  32  PC of instruction, carried through
- i_rs_data  in  32  register-file read of rs
- i_rt_data  in  32  register-file read of rt
- i_stall  in  1  hold ID/EX register contents
- i_flush  in  1  squash: next o_valid = 0
- o_valid  out  1  issued slot valid
- o_alu_control  out  6  ALU function code
- o_op1  out  32  ALU operand 1 (shift amount for shifts)
- o_op2  out  32  ALU operand 2
- o_rd  out  5  destination register
- o_reg_write  out  1  writeback enable
- o_ov_trap  out  1  overflow from ALU must raise exception (ADD, SUB, ADDI)
- o_illegal  out  1  unsupported encoding
- o_pc  out  32  carried PC

## Operation
- R-type (opcode 000000): o_alu_control = funct for AND/OR/XOR/NOR/ADD/ADDU/SUB/SUBU/SLT/SLTU; op1 = rs_data, op2 = rt_data, rd = instr[15:11].
- SLL/SRL/SRA: op1 = {27'b0, shamt}, op2 = rt_data. SRL with instr[21]=1 → ROTR 111110.
- SLLV/SRLV/SRAV: op1 = {27'b0, rs_data[4:0]}, op2 = rt_data. SRLV with instr[6]=1 → ROTRV 111111.
- I-type, rd = instr[20:16], op1 = rs_data: ADDI(001000)→100000, ADDIU(001001)→100001, SLTI(001010)→101010, SLTIU(001011)→101011 with op2 = sign-extended imm; ANDI(001100)→100100, ORI(001101)→100101, XORI(001110)→100110 with op2 = zero-extended imm; LUI(001111)→111100, op2 = {16'b0, imm}, op1 = 0.
- o_ov_trap = 1 only for ADD, SUB, ADDI.
- o_reg_write = valid & ~illegal & (rd != 0).
- Any other opcode/funct: o_illegal = 1, o_alu_control = 000000 forced? No — forced to an unused code 111000 (ALU yields 0), reg_write 0, ov_trap 0.
- Bubble (i_valid = 0): o_valid = 0, o_reg_write = 0, o_ov_trap = 0, o_illegal = 0; data fields don't-care but registered as decoded.

## Timing
- Reset: every output 0 on the first edge with i_rst = 1; i_rst overrides flush/stall.
- Latency 1: decode of cycle N inputs visible on outputs after edge N+1.
- Priority per edge: i_rst > i_flush > i_stall > load.
- i_flush: o_valid, o_reg_write, o_ov_trap, o_illegal ← 0; other fields unchanged.
- i_stall (no flush): all outputs hold; inputs ignored. Stall of arbitrary length; release loads current inputs.
- Flush and stall together: flush wins, slot becomes bubble and remains bubble while stall persists.
- No combinational path input → output.

## Structure
- Shared include alu_defs.vh: ALU function-code localparams (incl. ROTR/ROTRV, LUI, illegal 111000) and opcode/funct constants; ALU and this block both use it.
- Sub-module alu_issue_dec: purely combinational instruction decoder; top holds ID/EX register and stall/flush/reset logic.

## Test plan
- Reset: hold i_rst 2 cycles with valid ADD input → all outputs 0; release → ADD issued next edge.
- `addi $5,$3,-1` (0x2065FFFF), rs_data 7 → control 100000, op1 7, op2 0xFFFFFFFF, rd 5, reg_write 1, ov_trap 1.
- `ori $2,$0,0x8000` → control 100101, op2 0x00008000; `lui $4,0x1234` → control 111100, op2 0x00001234, op1 0.
- `sll $0,$0,0` (nop) → reg_write 0; `rotr $9,$8,4` (srl with bit21) → control 111110, op1 4; `srav $3,$4,$5` with rs_data 0xFFFFFF23 → op1 3.
- Stall 3 cycles mid-stream with changing inputs → outputs constant; flush+stall same cycle → o_valid 0, stays 0 until stall drops.
- Opcode 111111 → o_illegal 1, control 111000, reg_write 0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants for the decode/issue stage and the execute ALU:
// opcodes, R-type funct values, ALU function codes and the ID/EX slot type.
package alu_issue_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type funct field values
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // ALU function codes (R-type codes reuse the funct value)
  localparam logic [5:0] ALU_ADD     = F_ADD;
  localparam logic [5:0] ALU_ADDU    = F_ADDU;
  localparam logic [5:0] ALU_AND     = F_AND;
  localparam logic [5:0] ALU_OR      = F_OR;
  localparam logic [5:0] ALU_XOR     = F_XOR;
  localparam logic [5:0] ALU_SLT     = F_SLT;
  localparam logic [5:0] ALU_SLTU    = F_SLTU;
  localparam logic [5:0] ALU_ROTR    = 6'b111110;
  localparam logic [5:0] ALU_ROTRV   = 6'b111111;
  localparam logic [5:0] ALU_LUI     = 6'b111100;
  localparam logic [5:0] ALU_ILLEGAL = 6'b111000;  // ALU produces 0

  // Decoder result for one instruction, before valid/bubble qualification
  typedef struct packed {
    logic [5:0]  alu_control;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wr_en;     // legal and rd != 0
    logic        ov_trap;
    logic        illegal;
  } dec_t;

  // Registered ID/EX slot
  typedef struct packed {
    logic        valid;
    logic [5:0]  alu_control;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        ov_trap;
    logic        illegal;
    logic [31:0] pc;
  } idex_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Purely combinational instruction decoder: instruction word plus register
// read data in, ALU function code, operands and writeback controls out.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output dec_t        dec_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        unused_rs_field;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign imm    = instr_i[15:0];
  assign shamt  = instr_i[10:6];
  // The rs index itself is consumed by the register file, not here.
  assign unused_rs_field = ^instr_i[25:22];

  // Decode opcode/funct into ALU control, operand selection and flags
  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave
    // a field unassigned and infer a latch.
    dec_o.alu_control = ALU_ILLEGAL;
    dec_o.op1         = rs_data_i;
    dec_o.op2         = rt_data_i;
    dec_o.rd          = 5'd0;
    dec_o.ov_trap     = 1'b0;
    dec_o.illegal     = 1'b1;
    dec_o.wr_en       = 1'b0;

    unique case (opcode)
      OP_RTYPE: begin
        dec_o.rd      = instr_i[15:11];
        dec_o.illegal = 1'b0;
        unique case (funct)
          F_AND, F_OR, F_XOR, F_NOR, F_ADDU, F_SUBU, F_SLT, F_SLTU: begin
            dec_o.alu_control = funct;
          end
          F_ADD, F_SUB: begin
            dec_o.alu_control = funct;
            dec_o.ov_trap     = 1'b1;
          end
          F_SLL, F_SRA: begin
            dec_o.alu_control = funct;
            dec_o.op1         = {27'b0, shamt};
          end
          F_SRL: begin
            // Bit 21 (low bit of the rs field) selects rotate
            dec_o.alu_control = instr_i[21] ? ALU_ROTR : funct;
            dec_o.op1         = {27'b0, shamt};
          end
          F_SLLV, F_SRAV: begin
            dec_o.alu_control = funct;
            dec_o.op1         = {27'b0, rs_data_i[4:0]};
          end
          F_SRLV: begin
            // Bit 6 (low bit of the shamt field) selects rotate
            dec_o.alu_control = instr_i[6] ? ALU_ROTRV : funct;
            dec_o.op1         = {27'b0, rs_data_i[4:0]};
          end
          default: begin
            dec_o.illegal = 1'b1;
            dec_o.rd      = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_o.alu_control = ALU_ADD;
        dec_o.op2         = sext16(imm);
        dec_o.ov_trap     = 1'b1;
      end
      OP_ADDIU: begin
        dec_o.alu_control = ALU_ADDU;
        dec_o.op2         = sext16(imm);
      end
      OP_SLTI: begin
        dec_o.alu_control = ALU_SLT;
        dec_o.op2         = sext16(imm);
      end
      OP_SLTIU: begin
        dec_o.alu_control = ALU_SLTU;
        dec_o.op2         = sext16(imm);
      end
      OP_ANDI: begin
        dec_o.alu_control = ALU_AND;
        dec_o.op2         = zext16(imm);
      end
      OP_ORI: begin
        dec_o.alu_control = ALU_OR;
        dec_o.op2         = zext16(imm);
      end
      OP_XORI: begin
        dec_o.alu_control = ALU_XOR;
        dec_o.op2         = zext16(imm);
      end
      OP_LUI: begin
        dec_o.alu_control = ALU_LUI;
        dec_o.op1         = 32'd0;
        dec_o.op2         = zext16(imm);
      end
      default: ;
    endcase

    // All I-type encodings share the rt destination and legality
    if (opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                       OP_ANDI, OP_ORI, OP_XORI, OP_LUI}) begin
      dec_o.rd      = instr_i[20:16];
      dec_o.illegal = 1'b0;
    end

    dec_o.wr_en = ~dec_o.illegal & (dec_o.rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: decodes the instruction in the decode slot and
// registers the result into the ID/EX boundary, honouring reset, flush
// (bubble insertion) and stall (hold) from the hazard unit.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [5:0]  o_alu_control,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic        o_ov_trap,
  output logic        o_illegal,
  output logic [31:0] o_pc
);

  dec_t  dec;
  idex_t idex_q, idex_d;

  alu_issue_dec u_dec (
    .instr_i   (i_instr),
    .rs_data_i (i_rs_data),
    .rt_data_i (i_rt_data),
    .dec_o     (dec)
  );

  // Next ID/EX contents: flush clears the qualifiers, stall holds, else load
  always_comb begin
    idex_d = idex_q;
    if (i_flush) begin
      // Data fields stay as they were; only the slot stops being live
      idex_d.valid     = 1'b0;
      idex_d.reg_write = 1'b0;
      idex_d.ov_trap   = 1'b0;
      idex_d.illegal   = 1'b0;
    end else if (!i_stall) begin
      // Bubbles still capture decoded data but never assert side effects
      idex_d.valid       = i_valid;
      idex_d.alu_control = dec.alu_control;
      idex_d.op1         = dec.op1;
      idex_d.op2         = dec.op2;
      idex_d.rd          = dec.rd;
      idex_d.reg_write   = i_valid & dec.wr_en;
      idex_d.ov_trap     = i_valid & dec.ov_trap;
      idex_d.illegal     = i_valid & dec.illegal;
      idex_d.pc          = i_pc;
    end
  end

  // ID/EX register with synchronous reset taking priority over everything
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (i_rst) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign o_valid       = idex_q.valid;
  assign o_alu_control = idex_q.alu_control;
  assign o_op1         = idex_q.op1;
  assign o_op2         = idex_q.op2;
  assign o_rd          = idex_q.rd;
  assign o_reg_write   = idex_q.reg_write;
  assign o_ov_trap     = idex_q.ov_trap;
  assign o_illegal     = idex_q.illegal;
  assign o_pc          = idex_q.pc;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a reference model of the ID/EX slot is
// updated on every rising edge and compared against the DUT 1 ns later;
// directed vectors also pin selected outputs to hand-computed literals.
module tb_alu_issue;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_instr, i_pc, i_rs_data, i_rt_data;
  logic        i_stall, i_flush;
  logic        o_valid, o_reg_write, o_ov_trap, o_illegal;
  logic [5:0]  o_alu_control;
  logic [31:0] o_op1, o_op2, o_pc;
  logic [4:0]  o_rd;

  int total = 0;
  int bad   = 0;
  logic [31:0] pc_cnt = 32'h0000_1000;

  alu_issue dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr),
    .i_pc(i_pc), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_stall(i_stall), .i_flush(i_flush), .o_valid(o_valid),
    .o_alu_control(o_alu_control), .o_op1(o_op1), .o_op2(o_op2),
    .o_rd(o_rd), .o_reg_write(o_reg_write), .o_ov_trap(o_ov_trap),
    .o_illegal(o_illegal), .o_pc(o_pc)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction semantics from the ISA point of view: which mnemonic, which
  // ALU code, which operands.
  function automatic void ref_decode(
    input  logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
    output logic [5:0] ctrl, output logic [31:0] a, output logic [31:0] b,
    output logic [4:0] rd, output logic legal, output logic trap);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    op = ins[31:26]; fn = ins[5:0]; imm = ins[15:0];
    ctrl = 6'h38; a = rs; b = rt; rd = 5'd0; legal = 1'b0; trap = 1'b0;
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                     6'h2A, 6'h2B}) begin
        legal = 1'b1; ctrl = fn; trap = (fn == 6'h20) || (fn == 6'h22);
      end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
        legal = 1'b1; a = 32'(ins[10:6]);
        ctrl = (fn == 6'h02 && ins[21]) ? 6'h3E : fn;
      end else if (fn inside {6'h04, 6'h06, 6'h07}) begin
        legal = 1'b1; a = rs % 32;
        ctrl = (fn == 6'h06 && ins[6]) ? 6'h3F : fn;
      end
      if (legal) rd = ins[15:11];
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      legal = 1'b1; rd = ins[20:16]; a = rs;
      if (op <= 6'h0B) b = 32'(signed'(imm));
      else             b = 32'(imm);
      case (op)
        6'h08:   begin ctrl = 6'h20; trap = 1'b1; end
        6'h09:   ctrl = 6'h21;
        6'h0A:   ctrl = 6'h2A;
        6'h0B:   ctrl = 6'h2B;
        6'h0C:   ctrl = 6'h24;
        6'h0D:   ctrl = 6'h25;
        6'h0E:   ctrl = 6'h26;
        default: begin ctrl = 6'h3C; a = 32'd0; end
      endcase
    end
  endfunction

  logic        m_valid, m_rw, m_ov, m_ill, m_known;
  logic [5:0]  m_ctrl;
  logic [31:0] m_op1, m_op2, m_pc;
  logic [4:0]  m_rd;

  // Update model on each edge, then compare the DUT once outputs settle
  always @(posedge i_clk) begin
    logic [5:0]  c;
    logic [31:0] a, b;
    logic [4:0]  d;
    logic        lg, tp;
    if (i_rst) begin
      {m_valid, m_rw, m_ov, m_ill} = '0;
      m_ctrl = '0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_pc = '0;
      m_known = 1'b1;
    end else if (i_flush) begin
      {m_valid, m_rw, m_ov, m_ill} = '0;
    end else if (!i_stall) begin
      ref_decode(i_instr, i_rs_data, i_rt_data, c, a, b, d, lg, tp);
      m_valid = i_valid;
      m_ctrl  = c;
      m_op1   = a; m_op2 = b; m_rd = d;
      m_rw    = i_valid && lg && (d != 0);
      m_ov    = i_valid && tp;
      m_ill   = i_valid && !lg;
      m_pc    = i_pc;
      m_known = lg;   // operands/rd of an illegal encoding are don't-care
    end
    #1;
    check("valid",     32'(o_valid),       32'(m_valid));
    check("reg_write", 32'(o_reg_write),   32'(m_rw));
    check("ov_trap",   32'(o_ov_trap),     32'(m_ov));
    check("illegal",   32'(o_illegal),     32'(m_ill));
    check("alu_ctrl",  32'(o_alu_control), 32'(m_ctrl));
    check("pc",        o_pc,               m_pc);
    if (m_known) begin
      check("op1", o_op1,      m_op1);
      check("op2", o_op2,      m_op2);
      check("rd",  32'(o_rd),  32'(m_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic st, input logic fl);
    @(negedge i_clk);
    i_valid = v; i_instr = ins; i_rs_data = rs; i_rt_data = rt;
    i_stall = st; i_flush = fl; i_pc = pc_cnt;
    pc_cnt = pc_cnt + 32'd4;
    @(posedge i_clk);
    #2;
  endtask

  localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;

  initial begin
    i_rst = 1'b1; i_valid = 1'b1; i_instr = ADD_3_1_2; i_pc = 32'h0;
    i_rs_data = 32'd5; i_rt_data = 32'd6; i_stall = 1'b0; i_flush = 1'b0;

    // Reset held two cycles with a valid ADD presented
    drive(1, ADD_3_1_2, 5, 6, 0, 0);
    drive(1, ADD_3_1_2, 5, 6, 0, 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_ctrl",  32'(o_alu_control), 0);
    check("rst_op1",   o_op1, 0);
    i_rst = 1'b0;
    drive(1, ADD_3_1_2, 5, 6, 0, 0);
    check("add_ctrl", 32'(o_alu_control), 32'h20);
    check("add_rd",   32'(o_rd), 3);
    check("add_trap", 32'(o_ov_trap), 1);

    // addi $5,$3,-1
    drive(1, 32'h2065_FFFF, 7, 32'h55, 0, 0);
    check("addi_op2", o_op2, 32'hFFFF_FFFF);
    check("addi_op1", o_op1, 7);
    check("addi_rw",  32'(o_reg_write), 1);
    // ori $2,$0,0x8000 / lui $4,0x1234
    drive(1, 32'h3402_8000, 0, 9, 0, 0);
    check("ori_op2",  o_op2, 32'h0000_8000);
    check("ori_ctrl", 32'(o_alu_control), 32'h25);
    drive(1, 32'h3C04_1234, 32'hDEAD, 9, 0, 0);
    check("lui_op1",  o_op1, 0);
    check("lui_ctrl", 32'(o_alu_control), 32'h3C);
    // nop, rotr $9,$8,4, srav $3,$4,$5, rotrv $6,$7,$8
    drive(1, 32'h0000_0000, 0, 0, 0, 0);
    check("nop_rw", 32'(o_reg_write), 0);
    drive(1, 32'h0028_4902, 1, 32'hF000_000F, 0, 0);
    check("rotr_ctrl", 32'(o_alu_control), 32'h3E);
    check("rotr_op1",  o_op1, 4);
    drive(1, 32'h00A4_1807, 32'hFFFF_FF23, 32'h8000_0000, 0, 0);
    check("srav_op1", o_op1, 3);
    drive(1, 32'h0107_3046, 32'h0000_0021, 32'h1234_5678, 0, 0);
    check("rotrv_ctrl", 32'(o_alu_control), 32'h3F);
    // assorted ALU ops, rd=0 cases, trap without writeback
    drive(1, 32'h00A6_202A, 32'hFFFF_FFFF, 1, 0, 0);   // slt
    drive(1, 32'h0043_0827, 32'hF0F0, 32'h0F0F, 0, 0); // nor
    drive(1, 32'h3827_F0F0, 3, 0, 0, 0);               // xori
    drive(1, 32'h2C48_8001, 3, 0, 0, 0);               // sltiu
    check("sltiu_op2", o_op2, 32'hFFFF_8001);
    drive(1, 32'h3060_00FF, 3, 0, 0, 0);               // andi $0
    drive(1, 32'h2020_0001, 3, 0, 0, 0);               // addi $0
    check("addi0_trap", 32'(o_ov_trap), 1);
    check("addi0_rw",   32'(o_reg_write), 0);
    // illegal encodings
    drive(1, 32'hFC00_0000, 1, 2, 0, 0);
    check("ill_flag", 32'(o_illegal), 1);
    check("ill_ctrl", 32'(o_alu_control), 32'h38);
    check("ill_rw",   32'(o_reg_write), 0);
    drive(1, 32'h03E0_0008, 1, 2, 0, 0);               // jr: unsupported funct
    // bubble
    drive(0, ADD_3_1_2, 11, 12, 0, 0);
    check("bub_valid", 32'(o_valid), 0);

    // Stall three cycles with changing inputs
    drive(1, 32'h016C_5022, 100, 30, 0, 0);            // sub $10,$11,$12
    for (int k = 0; k < 3; k++)
      drive(1, 32'h3402_0000 + 32'(k), 32'(k), 32'(k), 1, 0);
    check("stall_op1",  o_op1, 100);
    check("stall_ctrl", 32'(o_alu_control), 32'h22);
    drive(1, 32'h3827_F0F0, 8, 0, 0, 0);               // release loads xori
    check("rel_ctrl", 32'(o_alu_control), 32'h26);

    // Flush + stall, stall persists, then release
    drive(1, ADD_3_1_2, 1, 1, 1, 1);
    check("fs_valid", 32'(o_valid), 0);
    drive(1, ADD_3_1_2, 1, 1, 1, 0);
    drive(1, ADD_3_1_2, 1, 1, 1, 0);
    check("fs_hold_valid", 32'(o_valid), 0);
    check("fs_hold_rd",    32'(o_rd), 7);
    drive(1, ADD_3_1_2, 2, 3, 0, 0);
    check("fs_rel_valid", 32'(o_valid), 1);
    // Flush alone
    drive(1, 32'h00A6_202A, 4, 5, 0, 1);
    check("fl_rw", 32'(o_reg_write), 0);
    // Reset overrides flush and stall
    drive(1, 32'h2065_FFFF, 7, 0, 0, 0);
    i_rst = 1'b1;
    drive(1, 32'h2065_FFFF, 7, 0, 1, 1);
    check("rst2_op2", o_op2, 0);
    i_rst = 1'b0;
    drive(1, 32'h2065_FFFF, 7, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
